// File: rtl/fp32_mul_responder.sv
// fp32 multiplier behind a stb/ack operand/result handshake: RNE rounding, flush-to-zero,
// fixed five-edge latency from the last operand capture to z_stb.
module fp32_mul_responder #(
    parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
    input  logic        iClk,
    input  logic        iRstn,
    input  logic [31:0] data_a,
    input  logic        a_stb,
    output logic        a_ack,
    input  logic [31:0] data_b,
    input  logic        b_stb,
    output logic        b_ack,
    output logic [31:0] result,
    output logic        z_stb,
    input  logic        z_ack
);

    localparam int unsigned EW = 8;
    localparam int unsigned FW = 23;
    localparam int unsigned MW = FW + 1;
    localparam int unsigned PW = 2 * MW;
    localparam int unsigned XW = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_ROUND,
        S_PUT
    } state_t;

    state_t                state_q;
    logic                  have_a_q, have_b_q;
    logic [31:0]           a_q, b_q;
    logic                  sign_q;
    logic                  special_q;
    logic [31:0]           spec_res_q;
    logic [MW-1:0]         ma_q, mb_q;
    logic signed [XW-1:0]  exp_q;
    logic [PW-1:0]         p_q;
    logic [FW-1:0]         frac_q;
    logic                  guard_q, sticky_q;
    logic [31:0]           result_q;
    logic                  z_stb_q;

    assign a_ack  = (state_q == S_GET) && !have_a_q;
    assign b_ack  = (state_q == S_GET) && !have_b_q;
    assign result = result_q;
    assign z_stb  = z_stb_q;

    // Operand classification and special-case result, from the captured raw operands
    logic [EW-1:0]        ea_c, eb_c;
    logic [FW-1:0]        fa_c, fb_c;
    logic                 sign_c;
    logic                 a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_zero_c, b_zero_c;
    logic                 spec_c;
    logic [31:0]          spec_res_c;
    logic signed [XW-1:0] exp_sum_c;

    always_comb begin
        ea_c     = a_q[30:23];
        eb_c     = b_q[30:23];
        fa_c     = a_q[22:0];
        fb_c     = b_q[22:0];
        sign_c   = a_q[31] ^ b_q[31];
        a_nan_c  = (&ea_c) && (|fa_c);
        b_nan_c  = (&eb_c) && (|fb_c);
        a_inf_c  = (&ea_c) && !(|fa_c);
        b_inf_c  = (&eb_c) && !(|fb_c);
        a_zero_c = !(|ea_c);
        b_zero_c = !(|eb_c);
        exp_sum_c = $signed({2'b00, ea_c}) + $signed({2'b00, eb_c}) - 10'sd127;

        spec_c     = 1'b1;
        spec_res_c = {sign_c, 31'b0};
        if (a_nan_c || b_nan_c) begin
            spec_res_c = QNAN;
        end else if ((a_inf_c && b_zero_c) || (b_inf_c && a_zero_c)) begin
            spec_res_c = QNAN;
        end else if (a_inf_c || b_inf_c) begin
            spec_res_c = {sign_c, 8'hFF, 23'b0};
        end else if (!(a_zero_c || b_zero_c)) begin
            spec_c = 1'b0;
        end
    end

    // Normalise the 48-bit product to a 23-bit fraction plus guard/sticky
    logic [FW-1:0]        frac_n_c;
    logic                 guard_n_c, sticky_n_c;
    logic signed [XW-1:0] exp_n_c;

    always_comb begin
        if (p_q[PW-1]) begin
            frac_n_c   = p_q[46:24];
            guard_n_c  = p_q[23];
            sticky_n_c = |p_q[22:0];
            exp_n_c    = exp_q + 10'sd1;
        end else begin
            frac_n_c   = p_q[45:23];
            guard_n_c  = p_q[22];
            sticky_n_c = |p_q[21:0];
            exp_n_c    = exp_q;
        end
    end

    // Round to nearest even; the hidden bit is always 1, so an all-ones fraction carries
    logic                 inc_c, carry_c;
    logic [FW-1:0]        frac_r_c;
    logic signed [XW-1:0] exp_r_c;
    logic [31:0]          pack_c;

    always_comb begin
        inc_c    = guard_q && (sticky_q || frac_q[0]);
        carry_c  = inc_c && (&frac_q);
        frac_r_c = frac_q + FW'(inc_c);
        exp_r_c  = exp_q + $signed({9'b0, carry_c});
        if (special_q) begin
            pack_c = spec_res_q;
        end else if (exp_r_c >= 10'sd255) begin
            pack_c = {sign_q, 8'hFF, 23'b0};
        end else if (exp_r_c <= 10'sd0) begin
            pack_c = {sign_q, 31'b0};
        end else begin
            pack_c = {sign_q, exp_r_c[7:0], frac_r_c};
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q    <= S_IDLE;
            have_a_q   <= 1'b0;
            have_b_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            exp_q      <= '0;
            p_q        <= '0;
            frac_q     <= '0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            result_q   <= '0;
            z_stb_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_GET;
                S_GET: begin
                    if (a_stb && a_ack) begin
                        a_q      <= data_a;
                        have_a_q <= 1'b1;
                    end
                    if (b_stb && b_ack) begin
                        b_q      <= data_b;
                        have_b_q <= 1'b1;
                    end
                    if ((have_a_q || a_stb) && (have_b_q || b_stb)) begin
                        state_q <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_q     <= sign_c;
                    special_q  <= spec_c;
                    spec_res_q <= spec_res_c;
                    ma_q       <= {1'b1, fa_c};
                    mb_q       <= {1'b1, fb_c};
                    exp_q      <= exp_sum_c;
                    state_q    <= S_MULT;
                end
                S_MULT: begin
                    p_q     <= PW'(ma_q) * PW'(mb_q);
                    state_q <= S_NORM;
                end
                S_NORM: begin
                    frac_q   <= frac_n_c;
                    guard_q  <= guard_n_c;
                    sticky_q <= sticky_n_c;
                    exp_q    <= exp_n_c;
                    state_q  <= S_ROUND;
                end
                S_ROUND: begin
                    result_q <= pack_c;
                    state_q  <= S_PUT;
                end
                S_PUT: begin
                    // z_stb rises one edge after entering PUT to meet the five-edge latency
                    if (!z_stb_q) begin
                        z_stb_q <= 1'b1;
                    end else if (z_ack) begin
                        z_stb_q  <= 1'b0;
                        have_a_q <= 1'b0;
                        have_b_q <= 1'b0;
                        state_q  <= S_GET;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_mul_responder.sv
// Bench for fp32_mul_responder: cycle-level handshake model plus integer-arithmetic fp32 product.
module tb_fp32_mul_responder;

    logic        iClk = 1'b0;
    logic        iRstn = 1'b0;
    logic [31:0] data_a = '0;
    logic        a_stb = 1'b0;
    logic        a_ack;
    logic [31:0] data_b = '0;
    logic        b_stb = 1'b0;
    logic        b_ack;
    logic [31:0] result;
    logic        z_stb;
    logic        z_ack = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    fp32_mul_responder dut (
        .iClk   (iClk),
        .iRstn  (iRstn),
        .data_a (data_a),
        .a_stb  (a_stb),
        .a_ack  (a_ack),
        .data_b (data_b),
        .b_stb  (b_stb),
        .b_ack  (b_ack),
        .result (result),
        .z_stb  (z_stb),
        .z_ack  (z_ack)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference product: exact integer product, then round the value to 24 significant bits
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        logic [22:0] fa, fb;
        longint unsigned p, q, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return 32'h7FC0_0000;
        if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC0_0000;
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'b0};
        if (ea == 0 || eb == 0) return {s, 31'b0};
        p  = (longint'(fa) + (64'd1 << 23)) * (longint'(fb) + (64'd1 << 23));
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'b0};
        if (e <= 0) return {s, 31'b0};
        return {s, 8'(e), q[22:0]};
    endfunction

    // Handshake model: 0 after reset, 1 collecting operands, 2 computing, 3 result offered
    int          m_phase = 0;
    int          m_cnt = 0;
    logic        m_have_a = 1'b0, m_have_b = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [31:0] m_res = '0;
    logic        m_z = 1'b0;

    always @(posedge iClk or negedge iRstn) begin
        logic        na, nb;
        logic [31:0] va, vb;
        if (!iRstn) begin
            m_phase  <= 0;
            m_have_a <= 1'b0;
            m_have_b <= 1'b0;
            m_res    <= '0;
            m_z      <= 1'b0;
            m_cnt    <= 0;
        end else begin
            case (m_phase)
                0: m_phase <= 1;
                1: begin
                    na = m_have_a; nb = m_have_b; va = m_a; vb = m_b;
                    if (!m_have_a && a_stb) begin na = 1'b1; va = data_a; end
                    if (!m_have_b && b_stb) begin nb = 1'b1; vb = data_b; end
                    m_have_a <= na; m_have_b <= nb; m_a <= va; m_b <= vb;
                    if (na && nb) begin
                        m_phase <= 2;
                        m_cnt   <= 4;
                        m_res   <= ref_mul(va, vb);
                    end
                end
                2: begin
                    if (m_cnt == 0) begin
                        m_phase <= 3;
                        m_z     <= 1'b1;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: begin
                    if (z_ack) begin
                        m_phase  <= 1;
                        m_z      <= 1'b0;
                        m_have_a <= 1'b0;
                        m_have_b <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge iClk) begin
        #2;
        chk("a_ack", {31'b0, a_ack}, {31'b0, (m_phase == 1) && !m_have_a});
        chk("b_ack", {31'b0, b_ack}, {31'b0, (m_phase == 1) && !m_have_b});
        chk("z_stb", {31'b0, z_stb}, {31'b0, m_z});
        if (m_z || !iRstn) chk("result", result, m_res);
    end

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int da, input int db,
                           input int hold, input bit keep, output logic [31:0] got);
        bit          ad = 0, bd = 0;
        int          t_acc = 0;
        int          k = 0;
        logic [31:0] first;
        got = '0;
        while (!(ad && bd) && k < 100) begin
            @(negedge iClk);
            data_a = a;
            data_b = b;
            a_stb  = (k >= da) && (keep || !ad);
            b_stb  = (k >= db) && (keep || !bd);
            if (a_stb && a_ack && !ad) begin ad = 1; t_acc = cyc + 1; end
            if (b_stb && b_ack && !bd) begin bd = 1; t_acc = cyc + 1; end
            k++;
        end
        if (!(ad && bd)) begin
            chk("accept_timeout", 32'(k), 32'(0));
            a_stb = 0; b_stb = 0;
            return;
        end
        k = 0;
        while (!z_stb && k < 50) begin
            @(negedge iClk);
            if (!keep) begin a_stb = 0; b_stb = 0; end
            k++;
        end
        if (!z_stb) begin
            chk("z_timeout", 32'(k), 32'(0));
            a_stb = 0; b_stb = 0;
            return;
        end
        chk("latency", 32'(cyc - t_acc), 32'd5);
        first = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge iClk);
            chk("hold_result", result, first);
            chk("hold_z_stb", {31'b0, z_stb}, 32'd1);
            chk("hold_acks", {30'b0, a_ack, b_ack}, 32'd0);
        end
        z_ack = 1;
        a_stb = 0;
        b_stb = 0;
        got = result;
        @(negedge iClk);
        z_ack = 0;
        chk("ack_return", {30'b0, a_ack, b_ack}, 32'd3);
        chk("z_drop", {31'b0, z_stb}, 32'd0);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: begin
                r[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 1) r[22:0] = '0;
            end
            1: r[30:23] = 8'h00;
            2: r[30:23] = 8'($urandom_range(126, 128));
            3: r[30:23] = 8'($urandom_range(1, 40));
            4: r[30:23] = 8'($urandom_range(200, 254));
            5: r[22:0] = '1;
            default: ;
        endcase
        return r;
    endfunction

    logic [31:0] dir_a [10];
    logic [31:0] dir_b [10];
    logic [31:0] dir_z [10];

    initial begin
        logic [31:0] got, got2;
        bit          saw_z;
        dir_a = '{32'h40000000, 32'hC0000000, 32'h3FC00000, 32'h3F800001, 32'h3F800000,
                  32'h7F800000, 32'hFF800000, 32'h7F7FFFFF, 32'h00800000, 32'h00000001};
        dir_b = '{32'h40400000, 32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h3F800000,
                  32'h00000000, 32'h40000000, 32'h40000000, 32'h00800000, 32'h40000000};
        dir_z = '{32'h40C00000, 32'hC0C00000, 32'h40100000, 32'h3F800002, 32'h3F800000,
                  32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h00000000, 32'h00000000};

        // Pin the reference model against hand-computed products
        chk("model_pin_2x3", ref_mul(dir_a[0], dir_b[0]), 32'h40C00000);
        chk("model_pin_round", ref_mul(dir_a[3], dir_b[3]), 32'h3F800002);
        chk("model_pin_ovf", ref_mul(dir_a[7], dir_b[7]), 32'h7F800000);
        chk("model_pin_ftz", ref_mul(dir_a[8], dir_b[8]), 32'h00000000);

        repeat (2) @(negedge iClk);
        #1;
        chk("reset_outputs", {result[31:3], a_ack, b_ack, z_stb}, 32'd0);
        @(negedge iClk);
        iRstn = 1;

        for (int i = 0; i < 10; i++) begin
            run_txn(dir_a[i], dir_b[i], 0, 0, 0, 0, got);
            chk($sformatf("directed_%0d", i), got, dir_z[i]);
        end

        run_txn(32'h40000000, 32'h40400000, 0, 3, 1, 0, got);
        chk("stagger_a_first", got, 32'h40C00000);
        run_txn(32'h40000000, 32'h40400000, 3, 0, 0, 0, got2);
        chk("stagger_b_first", got2, got);

        run_txn(32'h3FC00000, 32'h3FC00000, 0, 0, 10, 1, got);
        chk("backpressure", got, 32'h40100000);

        // Reset two cycles after capture: everything clears, no result follows
        @(negedge iClk);
        data_a = 32'h40000000; data_b = 32'h40400000;
        a_stb = 1; b_stb = 1;
        @(negedge iClk);
        a_stb = 0; b_stb = 0;
        @(negedge iClk);
        #1 iRstn = 0;
        #1;
        chk("async_reset", {result[31:3], a_ack, b_ack, z_stb}, 32'd0);
        chk("async_reset_result", result, 32'd0);
        repeat (2) @(negedge iClk);
        #1 iRstn = 1;
        saw_z = 0;
        repeat (12) begin
            @(negedge iClk);
            if (z_stb) saw_z = 1;
        end
        chk("no_z_after_reset", {31'b0, saw_z}, 32'd0);
        run_txn(32'h40000000, 32'h40400000, 0, 0, 0, 0, got);
        chk("post_reset_txn", got, 32'h40C00000);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] ra, rb;
            ra = rand_op();
            rb = rand_op();
            run_txn(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
            chk("random_txn", got, ref_mul(ra, rb));
        end

        repeat (3) @(negedge iClk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule

// File: doc/fp32_mul_responder.md
Name: fp32_mul_responder

Overview:
Single-precision IEEE-754 floating-point multiplier that acts as the responder side of the team's stb/ack operand/result handshake. Matrix and vector engines are initiators: they drive operands with a_stb/b_stb and collect the product on z_stb/z_ack. One instance serves one multiplier lane.
- Fixed latency.
- Round-to-nearest-even.
- Flush-to-zero for subnormals.

Parameters:
QNAN, 32'h7FC0_0000, canonical quiet NaN returned for all invalid results.

Ports:
iClk  input  1  clock, all logic on the rising edge.
iRstn  input  1  asynchronous active-low reset.
data_a  input  32  operand A (fp32).
a_stb  input  1  operand A valid.
a_ack  output  1  operand A accepted.
data_b  input  32  operand B (fp32).
b_stb  input  1  operand B valid.
b_ack  output  1  operand B accepted.
result  output  32  product (fp32).
z_stb  output  1  result valid.
z_ack  input  1  result consumed.

Behaviour:
- Reset is async on iRstn low.
  - State goes to IDLE.
  - a_ack=0, b_ack=0, z_stb=0, result=0.
  - Operand-captured flags are cleared.
  - Reset mid-operation discards any partial operand or in-flight product; no z_stb follows.
- State sequence: IDLE -> GET -> UNPACK -> MULT -> NORM -> ROUND -> PUT -> GET.
  - IDLE lasts exactly one cycle after reset release.
- GET:
  - a_ack = ~have_a; b_ack = ~have_b. Both are combinational from registered state.
  - An operand is captured on any edge where its stb and ack are both 1.
  - A and B may be captured in the same cycle or in different cycles, in either order.
  - After capture, that ack drops to 0 and further stb on that input is ignored.
  - The block leaves GET on the edge where the second operand is captured.
- Latency: if the last operand is captured at edge t, z_stb rises at edge t+5. Special-case results keep the same latency.
- PUT:
  - z_stb=1; result is held stable.
  - On the edge where z_stb and z_ack are both 1, the block moves to GET with flags cleared.
  - z_stb=0 from the next cycle; acks return to 1 in that same cycle.
  - z_ack while z_stb=0 is ignored.
  - Initiators may keep stb high during PUT; no operand is accepted until GET is re-entered.
- Operands are unpacked into sign, 8-bit biased exponent and 23-bit fraction.
- Input exponent 0 (zero or subnormal) is treated as signed zero.
- Special cases (sign s = sa^sb):
  - Either input is NaN -> QNAN.
  - Inf x zero -> QNAN.
  - Inf x nonzero -> {s, 8'hFF, 0}.
  - Zero x finite -> {s, 31'b0}.
- Normal path:
  - ma and mb are 24 bits with the hidden 1. Product p = ma*mb is 48 bits.
  - e = ea + eb - 127, computed as a signed 10-bit value.
  - If p[47]=1: mantissa = p[47:24], guard = p[23], sticky = |p[22:0], e += 1.
  - Otherwise: mantissa = p[46:23], guard = p[22], sticky = |p[21:0].
  - RNE: increment the mantissa if guard & (sticky | mantissa[0]).
  - If the increment carries out, mantissa becomes 1.0 and e += 1.
- Range after rounding:
  - e >= 255 -> {s, 8'hFF, 23'b0} (overflow to infinity).
  - e <= 0 -> {s, 31'b0} (flush to zero, no subnormal output).
  - Otherwise pack {s, e[7:0], mantissa[22:0]}.
- No exception flags are produced. Sign of zero/inf results always follows sa^sb; NaN sign is fixed by QNAN.

Test Plan:
- Basic product:
  - 0x40000000 x 0x40400000 -> 0x40C00000.
  - 0xC0000000 x 0x40400000 -> 0xC0C00000.
  - 0x3FC00000 x 0x3FC00000 -> 0x40100000.
  - Both operands are presented in the same cycle; z_stb must rise exactly 5 edges after acceptance.
- Rounding: 0x3F800001 x 0x3F800001 -> 0x3F800002. Also check 0x3F800000 x 0x3F800000 -> 0x3F800000 with no increment.
- Specials and range:
  - 0x7F800000 x 0x00000000 -> 0x7FC00000.
  - 0xFF800000 x 0x40000000 -> 0xFF800000.
  - 0x7F7FFFFF x 0x40000000 -> 0x7F800000.
  - 0x00800000 x 0x00800000 -> 0x00000000.
  - 0x00000001 x 0x40000000 -> 0x00000000.
- Staggered handshake:
  - A at edge 0, B at edge 3: a_ack must be 0 during cycles 1-3, and z_stb must rise at edge 8.
  - Repeat with B first; the result must be identical.
- Backpressure: hold z_ack=0 for 10 cycles with a_stb/b_stb kept high. result and z_stb must stay stable, both acks must stay 0, and no second capture may occur. After z_ack, both acks must be 1 in the next cycle.
- Reset: pull iRstn low 2 cycles after operand capture. All outputs must clear asynchronously and z_stb must never assert. A fresh 2.0x3.0 transaction afterwards must return 0x40C00000.
